// File: rtl/fetch_pkg.sv
// Shared fetch-stage types, opcodes and immediate decoders.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int ILEN  = 32;
    localparam int IMM_W = 64;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // B-type immediate, sign-extended to IMM_W; callers cast down to XLEN.
    function automatic logic [IMM_W-1:0] imm_b(input logic [ILEN-1:0] instr);
        return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended to IMM_W; callers cast down to XLEN.
    function automatic logic [IMM_W-1:0] imm_j(input logic [ILEN-1:0] instr);
        return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry circular queue with flush; head is read combinationally.
// Latency: a pushed entry is visible at the head one edge later.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle; flush wins.
module fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    input  logic          flush,
    output logic          head_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_rdy && (cnt_q != '0) && !flush;
    assign do_push = push_vld && !flush && ((cnt_q != CW'(DEPTH)) || do_pop);

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign head_vld = (cnt_q != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: PC generator feeding a DEPTH-entry queue; IFQ_PREDICT_EN enables static prediction.
// Latency: fetched word reaches an empty queue's head one edge later; redirect target valid two edges after.
// Backpressure: decode valid/ready; full queue with no pop stalls fetch and holds imem_addr_o.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic [ILEN-1:0]            imem_instr_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [XLEN-1:0]            pc_o,
    output logic [ILEN-1:0]            instr_o,
    output logic                       pred_taken_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            pred;
    } ifq_entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] next_pc;
    logic            pred;
    logic            push;
    logic            pop;
    logic            full;
    ifq_entry_t      push_entry;
    ifq_entry_t      head_entry;
    logic [1:0]      unused_rpc_lo;

    assign unused_rpc_lo = redirect_pc_i[1:0];

    assign full = (count_o == CW'(DEPTH));
    assign pop  = valid_o && ready_i;
    assign push = start_i && !redirect_i && (!full || pop);

    // Next fetch address: sequential, or a statically predicted target.
    always_comb begin
        next_pc = fetch_pc + XLEN'(4);
        pred    = 1'b0;
`ifdef IFQ_PREDICT_EN
        if (imem_instr_i[6:0] == OPC_BRANCH && imem_instr_i[31]) begin
            next_pc = fetch_pc + XLEN'(imm_b(imem_instr_i));
            pred    = 1'b1;
        end else if (imem_instr_i[6:0] == OPC_JAL) begin
            next_pc = fetch_pc + XLEN'(imm_j(imem_instr_i));
            pred    = 1'b1;
        end
`endif
    end

    // Fetch PC: redirect overrides, otherwise advance only when a word is accepted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (push) begin
            fetch_pc <= next_pc;
        end
    end

    assign push_entry = '{pc: fetch_pc, instr: imem_instr_i, pred: pred};

    fetch_fifo #(
        .W     ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk (clk_i),
        .arst_n   (rst_i),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_rdy  (pop),
        .flush    (redirect_i),
        .head_vld (valid_o),
        .head_dat (head_entry),
        .count    (count_o)
    );

    assign imem_addr_o = fetch_pc;
    assign pc_o        = head_entry.pc;
    assign instr_o     = head_entry.instr;

`ifdef IFQ_PREDICT_EN
    assign pred_taken_o = valid_o && head_entry.pred;
`else
    logic unused_head_pred;
    assign unused_head_pred = head_entry.pred;
    assign pred_taken_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: random ready/start/redirect/reset stimulus.
module tb_fetch_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [2:0]  count;

    logic        start2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_instr2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        pred_taken2;
    logic [2:0]  count2;

    int          mem_mode;
    int          n_checks = 0;
    int          n_pass   = 0;

    ent_t        mq[$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    // mode 0: ADDI words; mode 1: ADDI plus a backward beq at 0x20; mode 2: hashed mix of control flow.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
        logic [31:0] h;
        logic [6:0]  opc;
        if (mode == 1 && a == 32'h20) return 32'hFE000EE3;
        if (mode != 2) return {a[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        case (h[9:7])
            3'd0:    opc = 7'b1100011;
            3'd1:    opc = 7'b1101111;
            3'd2:    opc = 7'b1100111;
            default: opc = 7'b0010011;
        endcase
        return {h[31:7], opc};
    endfunction

    function automatic void model_next(input logic [31:0] a, input logic [31:0] w,
                                       output logic [31:0] npc, output logic pr);
        longint off;
        off = 4;
        pr  = 1'b0;
`ifdef IFQ_PREDICT_EN
        if (w[6:0] == 7'h63 && w[31]) begin
            off = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 - 4096;
            pr  = 1'b1;
        end else if (w[6:0] == 7'h6F) begin
            off = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            if (w[31]) off = off - 1048576;
            pr  = 1'b1;
        end
`endif
        npc = a + 32'(off);
    endfunction

    assign imem_instr  = mem_word(imem_addr, mem_mode);
    assign imem_instr2 = mem_word(imem_addr2, mem_mode);

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .pc_o          (pc),
        .instr_o       (instr),
        .pred_taken_o  (pred_taken),
        .count_o       (count)
    );

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFFFFF8)) dut2 (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start2),
        .imem_addr_o   (imem_addr2),
        .imem_instr_i  (imem_instr2),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .valid_o       (valid2),
        .ready_i       (1'b1),
        .pc_o          (pc2),
        .instr_o       (instr2),
        .pred_taken_o  (pred_taken2),
        .count_o       (count2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a plain queue of fetched entries plus the fetch address.
    initial begin
        mq.delete();
        m_pc = 32'h0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_pc = 32'h0;
            end else if (redirect) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                logic        do_pop;
                logic [31:0] w;
                logic [31:0] npc;
                logic        pr;
                do_pop = ready && (mq.size() != 0);
                w = mem_word(m_pc, mem_mode);
                model_next(m_pc, w, npc, pr);
                if (do_pop) void'(mq.pop_front());
                if (start && (mq.size() < 4)) begin
                    mq.push_back('{pc: m_pc, instr: w, pred: pr});
                    m_pc = npc;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("count", 64'(count), 64'(mq.size()));
            chk("valid", 64'(valid), 64'(mq.size() != 0));
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));
            if (mq.size() != 0) begin
                chk("head_pc", 64'(pc), 64'(mq[0].pc));
                chk("head_instr", 64'(instr), 64'(mq[0].instr));
                chk("head_pred", 64'(pred_taken), 64'(mq[0].pred));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        start2      = 1'b0;
        mem_mode    = 0;
        step();

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_pred", 64'(pred_taken), 64'd0);
        chk("rst_addr2", 64'(imem_addr2), 64'hFFFFFFF8);

        // Streaming with ready held high
        rst_n = 1'b1;
        start = 1'b1;
        ready = 1'b1;
        chk("a_addr0", 64'(imem_addr), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("a_valid", 64'(valid), 64'd1);
            chk("a_pc", 64'(pc), 64'(4 * k));
            chk("a_addr", 64'(imem_addr), 64'(4 * k + 4));
        end

        // Fill to full with ready low, then drain in order
        ready = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) step();
        chk("b_count_full", 64'(count), 64'd4);
        chk("b_addr_hold", 64'(imem_addr), 64'h10);
        chk("b_head0", 64'(pc), 64'h0);
        ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("b_drain_pc", 64'(pc), 64'(4 * k));
        end

        // Redirect from a full queue
        ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("c_full", 64'(count), 64'd4);
        ready       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        chk("c_count0", 64'(count), 64'd0);
        chk("c_valid0", 64'(valid), 64'd0);
        chk("c_addr", 64'(imem_addr), 64'h100);
        step();
        chk("c_valid1", 64'(valid), 64'd1);
        chk("c_pc", 64'(pc), 64'h100);

        // Asynchronous reset mid-cycle with three entries held
        ready = 1'b0;
        step();
        step();
        chk("d_count3", 64'(count), 64'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("d_count", 64'(count), 64'd0);
        chk("d_valid", 64'(valid), 64'd0);
        chk("d_addr", 64'(imem_addr), 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Backward branch at 0x20
        mem_mode    = 1;
        ready       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        chk("e_addr", 64'(imem_addr), 64'h20);
        step();
        chk("e_head_pc", 64'(pc), 64'h20);
        chk("e_head_instr", 64'(instr), 64'hFE000EE3);
`ifdef IFQ_PREDICT_EN
        chk("e_next", 64'(imem_addr), 64'h1C);
        chk("e_pred", 64'(pred_taken), 64'd1);
`else
        chk("e_next", 64'(imem_addr), 64'h24);
        chk("e_pred", 64'(pred_taken), 64'd0);
`endif
        step();
        mem_mode = 2;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            start       = ($urandom_range(0, 9) != 0);
            ready       = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        redirect = 1'b0;
        start    = 1'b0;
        mem_mode = 0;

        // PC wrap from RESET_PC = 0xFFFFFFF8
        do_reset();
        start2 = 1'b1;
        chk("g_addr0", 64'(imem_addr2), 64'hFFFFFFF8);
        step();
        chk("g_addr1", 64'(imem_addr2), 64'hFFFFFFFC);
        chk("g_head", 64'(pc2), 64'hFFFFFFF8);
        step();
        chk("g_addr2", 64'(imem_addr2), 64'h0);
        step();
        chk("g_addr3", 64'(imem_addr2), 64'h4);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage for the pipelined RISC-V core. It replaces the bare PC register plus IF/ID latch with a PC generator feeding a DEPTH-entry instruction queue. Decode consumes entries through a valid/ready handshake, and branch resolution flushes the queue through a redirect port. Optional static prediction follows backward branches and JAL at fetch time.

## Interface
Parameters:
- XLEN, 32: PC width.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- RESET_PC, 0: fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  fetch enable; when low, no new fetches, but pops continue.
- imem_addr_o  out  XLEN  instruction-memory address; equals fetch_pc.
- imem_instr_i  in  32  instruction word; combinational from imem_addr_o in the same cycle.
- redirect_i  in  1  flush queue and restart fetch (branch/jump resolved in EX).
- redirect_pc_i  in  XLEN  restart address; bits [1:0] ignored and forced to 0.
- valid_o  out  1  head entry present (count ≠ 0).
- ready_i  in  1  decode accepts head; pop when valid_o && ready_i.
- pc_o  out  XLEN  head PC.
- instr_o  out  32  head instruction.
- pred_taken_o  out  1  head was fetched under a taken prediction.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- push = start_i && !redirect_i && (count < DEPTH || pop). Data pushed: {fetch_pc, imem_instr_i, pred}.
- On push, fetch_pc ← next_pc, where next_pc is fetch_pc + 4 unless the prediction below applies. Addition wraps modulo 2^XLEN.
- Pop advances the head pointer. Simultaneous push and pop is legal at any count, including full and empty. On empty, the push lands and the pop is suppressed because valid_o is 0.
- redirect_i has priority over everything:
  - count ← 0 and both pointers ← 0.
  - fetch_pc ← {redirect_pc_i[XLEN-1:2], 2'b00}.
  - Any pop in that cycle is discarded and no push occurs.
- When start_i is low, fetch_pc and existing entries hold, and decode can drain the queue.
- Head outputs are driven combinationally from the storage array. When valid_o = 0, pc_o, instr_o and pred_taken_o are don't-care; the bench checks them only while valid_o is high.
- Reset, asynchronous and possible mid-operation:
  - count_o = 0, valid_o = 0, pointers = 0, fetch_pc = RESET_PC, imem_addr_o = RESET_PC, pred_taken_o = 0.
  - Entries already in the queue are lost.

## Timing
- Fetch-to-head latency: an instruction fetched in cycle N is visible at the head in N+1 if the queue was empty.
- Redirect latency: redirect_i sampled at edge E0, target fetched in the cycle after E0, valid_o high after edge E1 (two edges).
- Throughput: one instruction per cycle sustained with ready_i held high.
- count_o and valid_o are registered and never glitch with ready_i.
- Full queue with ready_i = 0: imem_addr_o holds its value and no push occurs.

## Configuration
- IFQ_PREDICT_EN defined, evaluated on the pushed word:
  - opcode 1100011 (branch) with instr[31] = 1 (backward): next_pc = fetch_pc + B-immediate, pred = 1.
  - opcode 1101111 (JAL): next_pc = fetch_pc + J-immediate, pred = 1.
  - Otherwise sequential, pred = 0.
  - JALR is never predicted.
- IFQ_PREDICT_EN undefined: always sequential; pred_taken_o is tied 0 and the port remains.
- EX owns misprediction recovery, via redirect_i.

## Structure
- Package fetch_pkg holds:
  - ILEN = 32.
  - OPC_BRANCH = 7'b1100011 and OPC_JAL = 7'b1101111.
  - Functions imm_b(instr) and imm_j(instr) returning sign-extended XLEN values.
- Sub-module fetch_fifo holds storage, pointers and count, with push/pop/flush inputs and head outputs. PC generation and prediction stay in fetch_queue.

## Test plan
- Reset release, start_i = 1, ready_i = 1, DEPTH = 4 -> imem_addr_o = 0, 4, 8…; head pc_o 0x0, 0x4, 0x8 on consecutive cycles starting one cycle after the first fetch.
- ready_i = 0 for 6 cycles -> count_o rises to 4 and stops; imem_addr_o holds 0x10; raising ready_i resumes in order with no lost or duplicated PCs.
- Full queue, redirect_i = 1 with redirect_pc_i = 0x103 while ready_i = 1 -> next cycle count_o = 0 and imem_addr_o = 0x100; valid_o high two edges after redirect; head pc_o = 0x100.
- rst_i pulsed low asynchronously mid-cycle while count = 3 -> valid_o and count_o drop immediately; imem_addr_o = RESET_PC.
- XLEN = 32, RESET_PC = 0xFFFFFFF8, run 4 fetches -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- IFQ_PREDICT_EN: word 0xFE000EE3 (beq x0, x0, -4) at 0x20 -> next fetch 0x1C with pred_taken_o = 1 at that head; same word without the macro -> next fetch 0x24 with pred_taken_o = 0.
